// File: rtl/fifo_tx_pkg.sv
// Shared types and line levels for the FIFO nibble transmitter.
// FIFO_TX_PARITY_EN adds the PARITY state to the state enum.
package fifo_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
`ifdef FIFO_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP  = 3'd6
  } state_t;

  localparam logic TX_IDLE_LEVEL  = 1'b1;
  localparam logic TX_START_LEVEL = 1'b0;

endpackage

// File: rtl/fifo_tx_baud_cnt.sv
// Bit-period counter: counts CLKS_PER_BIT clocks, flags the last one, and
// restarts on a synchronous clear or after each completed bit.
module fifo_tx_baud_cnt #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_done = (cnt == LAST);

endmodule

// File: rtl/fifo_nibble_tx.sv
// Pops nibbles from the 4-bit FIFO and sends each as a start/data/stop frame.
// Define FIFO_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_nibble_tx
  import fifo_tx_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rnw,
  output logic              fifo_enable,
  output logic              tx,
  output logic              busy
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state, state_next;
  logic [DATA_W-1:0] shift, shift_next;
  logic [BW-1:0]     bit_cnt, bit_cnt_next;
  logic              tx_next, busy_next, enable_next, rnw_next;
  logic              bit_done, baud_clear;
`ifdef FIFO_TX_PARITY_EN
  logic              parity, parity_next;
`endif

  // The bit period restarts whenever the FSM changes state.
  assign baud_clear = (state_next != state);

  fifo_tx_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (baud_clear),
    .bit_done (bit_done)
  );

  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    tx_next      = tx;
    enable_next  = 1'b0;
    rnw_next     = 1'b1;
    busy_next    = 1'b0;
`ifdef FIFO_TX_PARITY_EN
    parity_next  = parity;
`endif
    case (state)
      IDLE: begin
        if (tx_en && !fifo_empty) begin
          state_next  = REQ;
          enable_next = 1'b1;
          rnw_next    = 1'b0;
        end
      end
      REQ: state_next = WAIT;
      WAIT: begin
        // FIFO read data is only trusted in this cycle.
        shift_next   = fifo_data;
        bit_cnt_next = '0;
`ifdef FIFO_TX_PARITY_EN
        parity_next  = 1'b0;
`endif
        tx_next      = TX_START_LEVEL;
        state_next   = START;
      end
      START: begin
        if (bit_done) begin
          tx_next    = shift[0];
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_next = shift >> 1;
`ifdef FIFO_TX_PARITY_EN
          parity_next = parity ^ shift[0];
`endif
          if (bit_cnt == LAST_BIT) begin
`ifdef FIFO_TX_PARITY_EN
            tx_next    = parity ^ shift[0];
            state_next = PARITY;
`else
            tx_next    = TX_IDLE_LEVEL;
            state_next = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
            tx_next      = shift_next[0];
          end
        end
      end
`ifdef FIFO_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          tx_next    = TX_IDLE_LEVEL;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) state_next = IDLE;
      end
      default: begin
        tx_next    = TX_IDLE_LEVEL;
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shift       <= '0;
      bit_cnt     <= '0;
      tx          <= TX_IDLE_LEVEL;
      busy        <= 1'b0;
      fifo_enable <= 1'b0;
      fifo_rnw    <= 1'b1;
`ifdef FIFO_TX_PARITY_EN
      parity      <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      shift       <= shift_next;
      bit_cnt     <= bit_cnt_next;
      tx          <= tx_next;
      busy        <= busy_next;
      fifo_enable <= enable_next;
      fifo_rnw    <= rnw_next;
`ifdef FIFO_TX_PARITY_EN
      parity      <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_nibble_tx.sv
// Scoreboard bench for fifo_nibble_tx with a behavioural 8-deep FIFO and a
// serial-line receiver; honours FIFO_TX_PARITY_EN like the design.
module tb_fifo_nibble_tx;
  localparam int DW  = 4;
  localparam int CPB = 4;
`ifdef FIFO_TX_PARITY_EN
  localparam int FRAME_LEN = 28;
  localparam logic [7:0] LINE_A = 8'b0010101;
  localparam logic [7:0] LINE_7 = 8'b0111011;
  localparam logic [7:0] LINE_D = 8'b0101111;
`else
  localparam int FRAME_LEN = 24;
  localparam logic [7:0] LINE_A = 8'b001011;
  localparam logic [7:0] LINE_7 = 8'b011101;
  localparam logic [7:0] LINE_D = 8'b010111;
`endif

  logic clk = 1'b0;
  logic rst, tx_en, fifo_empty, fifo_rnw, fifo_enable, tx, busy;
  logic [DW-1:0] fifo_data;

  fifo_nibble_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rnw(fifo_rnw), .fifo_enable(fifo_enable),
    .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: pop presents data on the following cycle and holds it.
  logic [DW-1:0] mem [8];
  logic [2:0]    rd_ptr = 3'd0, wr_ptr = 3'd0;
  int            cnt = 0;
  logic          push_req = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic [DW-1:0] fifo_out = '0;
  logic          pop, push;
  assign pop  = fifo_enable && !fifo_rnw && (cnt > 0);
  assign push = push_req && (cnt < 8);
  assign fifo_empty = (cnt == 0);
  assign fifo_data  = fifo_out;

  always @(posedge clk) begin
    if (pop) begin
      fifo_out <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + 3'd1;
    end
    if (push) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= wr_ptr + 3'd1;
    end
    cnt <= cnt + (push ? 1 : 0) - (pop ? 1 : 0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  logic [DW-1:0] exp_q[$];
  int frames_rx = 0, en_count = 0, last_stop_cyc = -100;
  int gap_hist[64];
  int len_hist[64];
  logic [7:0] line_hist[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_nib(input logic [DW-1:0] d);
    push_req  = 1'b1;
    push_data = d;
    exp_q.push_back(d);
    @(negedge clk);
    push_req = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int i = 0;
    while (frames_rx < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("frame_timeout", frames_rx >= target, 1);
  endtask

  task automatic wait_tx_low(input int budget);
    int i = 0;
    while (tx !== 1'b0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("start_timeout", tx, 0);
  endtask

  // One bit slot of CPB samples; the first sample may already be in hand.
  task automatic rx_slot(input bit have_first, output logic v, output bit ok, output bit ab);
    ok = 1'b1; ab = 1'b0; v = 1'bx;
    for (int i = 0; i < CPB; i++) begin
      if (i > 0 || !have_first) @(negedge clk);
      if (rst) begin
        ab = 1'b1;
        return;
      end
      if (i == 0) v = tx;
      else if (tx !== v) ok = 1'b0;
    end
  endtask

  initial begin : rx_mon
    logic v, p;
    bit ok, ab, stable;
    logic [DW-1:0] d, e;
    logic [7:0] line;
    int start_cyc;
    p = 1'b0; d = '0;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        start_cyc = cyc;
        if (frames_rx < 64) gap_hist[frames_rx] = cyc - last_stop_cyc - 1;
        check("busy_in_frame", busy, 1);
        line = 8'd0;
        rx_slot(1'b1, v, stable, ab);
        line = {line[6:0], v};
        for (int b = 0; b < DW && !ab; b++) begin
          rx_slot(1'b0, v, ok, ab);
          stable &= ok;
          d[b] = v;
          line = {line[6:0], v};
        end
`ifdef FIFO_TX_PARITY_EN
        if (!ab) begin
          rx_slot(1'b0, p, ok, ab);
          stable &= ok;
          line = {line[6:0], p};
        end
`endif
        if (!ab) begin
          rx_slot(1'b0, v, ok, ab);
          stable &= ok;
          line = {line[6:0], v};
        end
        if (ab) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          while (rst) @(negedge clk);
        end else begin
          check("frame_expected", exp_q.size() > 0, 1);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          check("rx_data", d, e);
`ifdef FIFO_TX_PARITY_EN
          check("rx_parity", p, ^e);
`endif
          check("stop_bit", v, 1);
          check("bit_width", stable, 1);
          last_stop_cyc = cyc;
          if (frames_rx < 64) begin
            line_hist[frames_rx] = line;
            len_hist[frames_rx]  = cyc - start_cyc + 1;
          end
          frames_rx++;
          @(negedge clk);
          if (!rst) check("busy_after_stop", busy, 0);
        end
      end
    end
  end

  initial begin : en_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && fifo_enable === 1'b1) begin
        en_count++;
        check("pop_rnw", fifo_rnw, 0);
        check("pop_single_cycle", prev, 0);
        check("pop_not_empty", cnt > 0, 1);
      end
      prev = fifo_enable;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base, en0;
    rst = 1'b0; tx_en = 1'b1;
    #1 rst = 1'b1;
    @(negedge clk);
    push_nib(4'hA);
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_enable", fifo_enable, 0);
    check("rst_rnw", fifo_rnw, 1);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("first_pop_enable", fifo_enable, 1);
    check("first_pop_rnw", fifo_rnw, 0);
    check("busy_rise", busy, 1);
    @(negedge clk);
    check("pop_end_enable", fifo_enable, 0);
    check("req_tx_high", tx, 1);
    @(negedge clk);
    check("tx_fall_latency", tx, 0);
    wait_frames(1, 100);
    check("line_A", line_hist[0], LINE_A);
    check("len_A", len_hist[0], FRAME_LEN);
    check("pops_A", en_count, 1);

    // Preloaded burst of 0..7.
    tx_en = 1'b0;
    for (int k = 0; k < 8; k++) push_nib(DW'(k));
    repeat (3) @(negedge clk);
    check("burst_full", cnt, 8);
    base = frames_rx; en0 = en_count;
    tx_en = 1'b1;
    wait_frames(base + 8, 8 * 40 + 50);
    for (int k = 1; k < 8; k++) check("burst_gap", gap_hist[base + k], 3);
    check("line_7", line_hist[base + 7], LINE_7);
    repeat (40) @(negedge clk);
    check("burst_empty", fifo_empty, 1);
    check("burst_pops", en_count, en0 + 8);

    // tx_en dropped during frame 1 of 3.
    base = frames_rx; en0 = en_count;
    push_nib(4'h8); push_nib(4'h9); push_nib(4'hB);
    wait_tx_low(20);
    repeat (CPB + 2) @(negedge clk);
    tx_en = 1'b0;
    wait_frames(base + 1, 60);
    repeat (30) @(negedge clk);
    check("drop_frames", frames_rx, base + 1);
    check("drop_pops", en_count, en0 + 1);
    check("drop_fifo_cnt", cnt, 2);
    tx_en = 1'b1;
    @(negedge clk);
    check("resume_enable", fifo_enable, 1);
    @(negedge clk);
    check("resume_tx_high", tx, 1);
    @(negedge clk);
    check("resume_tx_fall", tx, 0);
    wait_frames(base + 3, 120);

    // Reset in the middle of DATA while the line is low.
    base = frames_rx; en0 = en_count;
    push_nib(4'hC); push_nib(4'hD);
    wait_tx_low(20);
    repeat (CPB + 1) @(negedge clk);
    check("pre_reset_tx", tx, 0);
    rst = 1'b1;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_enable", fifo_enable, 0);
    check("async_rst_rnw", fifo_rnw, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_frames(base + 1, 80);
    check("line_D", line_hist[base], LINE_D);
    repeat (20) @(negedge clk);
    check("rst_frames", frames_rx, base + 1);
    check("rst_pops", en_count, en0 + 2);
    check("rst_fifo_empty", fifo_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
